// File: rtl/bw_io_misc_rpt_pkg.sv
// Shared defaults, types and the round-robin picker for the IO misc repeater arbiter.
package bw_io_misc_rpt_pkg;

    localparam int RPT_NREQ   = 4;
    localparam int RPT_W      = 7;
    localparam int RPT_DEPTH  = 2;
    localparam int RPT_MAXREQ = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } rpt_state_e;

    typedef struct packed {
        logic             last;
        logic [RPT_W-1:0] data;
    } rpt_beat_t;

    // First set bit of vld at or above ptr, wrapping at n; returns ptr if none is set.
    function automatic logic [2:0] rr_pick(input logic [RPT_MAXREQ-1:0] vld,
                                           input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        for (int i = RPT_MAXREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && vld[idx[2:0]]) pick = idx[2:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/bw_io_misc_rpt_fifo.sv
// Small synchronous FIFO; the head entry is read straight out of the storage registers.
module bw_io_misc_rpt_fifo
#(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
)(
    input  logic          rclk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/bw_io_misc_rpt_arb.sv
// Round-robin packet arbiter feeding the repeated misc channel through a small output FIFO.
module bw_io_misc_rpt_arb
    import bw_io_misc_rpt_pkg::*;
#(
    parameter int NREQ  = RPT_NREQ,
    parameter int W     = RPT_W,
    parameter int DEPTH = RPT_DEPTH
)(
    input  logic              rclk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_rdy,
    output logic              rpt_vld,
    output logic [W-1:0]      rpt_data,
    output logic              rpt_last,
    input  logic              rpt_rdy,
    output logic              busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    rpt_state_e    state;
    logic [GW-1:0] gnt_id;
    logic [GW-1:0] ptr;
    logic [GW-1:0] pick;
    logic [GW-1:0] next_ptr;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    beat_t         push_beat;
    beat_t         head_beat;

    assign pick     = GW'(rr_pick(RPT_MAXREQ'(req_vld), 3'(ptr), NREQ));
    assign next_ptr = (gnt_id == GW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    // Ready depends only on registered state, never on rpt_rdy.
    always_comb begin
        req_rdy = '0;
        if (state == LOCK && fifo_count < CW'(DEPTH)) req_rdy[gnt_id] = 1'b1;
    end

    assign push_beat.data = req_data[gnt_id*W +: W];
    assign push_beat.last = req_last[gnt_id];
    assign push           = req_vld[gnt_id] & req_rdy[gnt_id] & ~full;
    assign pop            = rpt_vld & rpt_rdy;

    always_ff @(posedge rclk) begin
        if (reset) begin
            state  <= IDLE;
            gnt_id <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: if (|req_vld) begin
                    gnt_id <= pick;
                    state  <= LOCK;
                end
                LOCK: if (push && push_beat.last) begin
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bw_io_misc_rpt_fifo #(.DW(W + 1), .DEPTH(DEPTH)) u_fifo (
        .rclk      (rclk),
        .reset     (reset),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (head_beat),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign rpt_vld  = ~empty;
    assign rpt_data = head_beat.data;
    assign rpt_last = head_beat.last;
    assign busy     = (state == LOCK) | ~empty;

endmodule

// File: tb/tb_bw_io_misc_rpt_arb.sv
// Randomised and directed bench for bw_io_misc_rpt_arb against a queue-based packet model.
module tb_bw_io_misc_rpt_arb;
    localparam int NREQ = 4, W = 7, DEPTH = 2, GW = 2;

    typedef logic [W:0] bq_t[$];

    logic              rclk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_vld, req_last, req_rdy;
    logic [NREQ*W-1:0] req_data;
    logic              rpt_vld, rpt_last, rpt_rdy, busy;
    logic [W-1:0]      rpt_data;

    bw_io_misc_rpt_arb #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
        .rclk(rclk), .reset(reset), .req_vld(req_vld), .req_data(req_data),
        .req_last(req_last), .req_rdy(req_rdy), .rpt_vld(rpt_vld), .rpt_data(rpt_data),
        .rpt_last(rpt_last), .rpt_rdy(rpt_rdy), .busy(busy)
    );

    always #5 rclk = ~rclk;

    int checks = 0, failures = 0;
    bq_t src_q [NREQ];
    int  hold [NREQ];
    // model: current packet owner (-1 = none), next search start, FIFO contents
    int  m_owner, m_ptr, cyc_cnt;
    bq_t m_q;
    logic [NREQ-1:0] acc_mask;
    bq_t out_log, exp_q;
    int  acc_log[$], acc_cyc0[$];
    bit  chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] bt(input logic last, input int d);
        return {last, W'(d)};
    endfunction

    always @(posedge rclk) begin : model
        logic [W:0] beat;
        bit acc, pp;
        cyc_cnt++;
        acc_mask = '0;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_q.delete();
        end else begin
            if (rpt_vld && rpt_rdy) out_log.push_back({rpt_last, rpt_data});
            for (int i = 0; i < NREQ; i++)
                if (req_vld[i] && req_rdy[i]) begin
                    acc_log.push_back(i);
                    if (i == 0) acc_cyc0.push_back(cyc_cnt);
                end
            acc = 0;
            beat = '0;
            pp = (m_q.size() > 0) && rpt_rdy;
            if (m_owner < 0) begin
                for (int k = 0; k < NREQ; k++)
                    if (m_owner < 0 && req_vld[GW'((m_ptr + k) % NREQ)]) m_owner = (m_ptr + k) % NREQ;
            end else if (m_q.size() < DEPTH && req_vld[GW'(m_owner)]) begin
                acc = 1;
                acc_mask[GW'(m_owner)] = 1'b1;
                beat = {req_last[GW'(m_owner)], req_data[m_owner*W +: W]};
            end
            if (pp) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(beat);
                if (beat[W]) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge rclk) begin : compare
        logic [NREQ-1:0] er;
        if (chk_en) begin
            er = (m_owner >= 0 && m_q.size() < DEPTH) ? (NREQ'(1) << m_owner) : '0;
            chk("req_rdy", 32'(req_rdy), 32'(er));
            chk("rpt_vld", 32'(rpt_vld), 32'(m_q.size() > 0));
            chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_q.size() > 0)));
            if (m_q.size() > 0) begin
                chk("rpt_data", 32'(rpt_data), 32'(m_q[0][W-1:0]));
                chk("rpt_last", 32'(rpt_last), 32'(m_q[0][W]));
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i] = (src_q[i].size() > 0) && (hold[i] == 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0][W-1:0] : W'($urandom);
            req_last[i] = (src_q[i].size() > 0) ? src_q[i][0][W] : 1'($urandom);
        end
    endtask

    task automatic cyc();
        drive();
        @(posedge rclk);
        @(negedge rclk);
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (hold[i] > 0) hold[i]--;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            hold[i] = 0;
        end
        out_log.delete(); acc_log.delete(); acc_cyc0.delete(); exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        clear_all();
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            done = (m_q.size() == 0) && (m_owner < 0);
            for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) done = 0;
            if (!done) cyc();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < out_log.size() && k < exp_q.size(); k++)
            chk(name, 32'(out_log[k]), 32'(exp_q[k]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rpt_rdy = 1'b1; chk_en = 0; cyc_cnt = 0;
        req_vld = '0; req_data = '0; req_last = '0;
        m_owner = -1; m_ptr = 0;
        clear_all();
        for (int i = 0; i < NREQ; i++) src_q[i].push_back(bt(1'($urandom), int'($urandom)));

        // reset with random inputs
        cyc();
        chk_en = 1;
        for (int n = 0; n < 3; n++) begin
            rpt_rdy = 1'($urandom);
            chk("rst_req_rdy", 32'(req_rdy), 32'd0);
            chk("rst_rpt_vld", 32'(rpt_vld), 32'd0);
            chk("rst_rpt_data", 32'(rpt_data), 32'd0);
            chk("rst_rpt_last", 32'(rpt_last), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            cyc();
        end
        reset = 1'b0;
        clear_all();
        repeat (2) cyc();
        chk("idle_busy", 32'(busy), 32'd0);

        // simultaneous single-beat requests
        do_reset();
        rpt_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++)
            for (int p = 0; p < 4; p++) src_q[i].push_back(bt(1'b1, 'h10 + i));
        for (int n = 0; n < 100 && out_log.size() < 12; n++) cyc();
        for (int k = 0; k < 12; k++) exp_q.push_back(bt(1'b1, 'h10 + k % 4));
        drain();
        while (out_log.size() > 12) void'(out_log.pop_back());
        chk_log("rr_order");
        chk("rr_gnt_spacing", 32'(acc_cyc0.size() >= 2 ? acc_cyc0[1] - acc_cyc0[0] : -1), 32'd8);

        // multi-beat lock
        do_reset();
        src_q[2].push_back(bt(0, 'h21)); src_q[2].push_back(bt(0, 'h22)); src_q[2].push_back(bt(1, 'h23));
        cyc();
        src_q[0].push_back(bt(1, 'h05));
        for (int n = 0; n < 20 && src_q[2].size() > 0; n++) begin
            chk("lock_rdy0", 32'(req_rdy[0]), 32'd0);
            cyc();
        end
        drain();
        exp_q.push_back(bt(0, 'h21)); exp_q.push_back(bt(0, 'h22));
        exp_q.push_back(bt(1, 'h23)); exp_q.push_back(bt(1, 'h05));
        chk_log("lock_order");

        // backpressure
        do_reset();
        rpt_rdy = 1'b0;
        for (int k = 0; k < 4; k++) src_q[1].push_back(bt(k == 3, 'h31 + k));
        repeat (8) cyc();
        chk("bp_accepted", 32'(acc_log.size()), 32'd2);
        chk("bp_rdy1", 32'(req_rdy[1]), 32'd0);
        rpt_rdy = 1'b1;
        drain();
        for (int k = 0; k < 4; k++) exp_q.push_back(bt(k == 3, 'h31 + k));
        chk_log("bp_order");

        // bubble mid-packet and pointer wrap
        do_reset();
        src_q[3].push_back(bt(0, 'h41)); src_q[3].push_back(bt(0, 'h42)); src_q[3].push_back(bt(1, 'h43));
        cyc();
        src_q[0].push_back(bt(1, 'h01));
        src_q[2].push_back(bt(1, 'h02));
        cyc();
        hold[3] = 2;
        drain();
        exp_q.push_back(bt(0, 'h41)); exp_q.push_back(bt(0, 'h42)); exp_q.push_back(bt(1, 'h43));
        exp_q.push_back(bt(1, 'h01)); exp_q.push_back(bt(1, 'h02));
        chk_log("wrap_order");
        chk("wrap_gnt_len", 32'(acc_log.size()), 32'd5);
        if (acc_log.size() == 5) begin
            chk("wrap_gnt3", 32'(acc_log[3]), 32'd0);
            chk("wrap_gnt4", 32'(acc_log[4]), 32'd2);
        end

        // reset mid-packet
        do_reset();
        rpt_rdy = 1'b0;
        for (int k = 0; k < 4; k++) src_q[1].push_back(bt(k == 3, 'h51 + k));
        repeat (4) cyc();
        chk("mid_fifo_vld", 32'(rpt_vld), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        clear_all();
        chk("mid_rst_vld", 32'(rpt_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
        src_q[1].push_back(bt(0, 'h61)); src_q[1].push_back(bt(1, 'h62));
        rpt_rdy = 1'b1;
        drain();
        exp_q.push_back(bt(0, 'h61)); exp_q.push_back(bt(1, 'h62));
        chk_log("mid_restart");

        // randomised traffic with bubbles, backpressure and occasional reset
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(3) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) src_q[i].push_back(bt(b == len - 1, int'($urandom)));
                end else if (src_q[i].size() > 0 && hold[i] == 0 && $urandom_range(15) == 0)
                    hold[i] = int'($urandom_range(1, 3));
            end
            rpt_rdy = ($urandom_range(9) < 7);
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
                clear_all();
            end else cyc();
        end
        rpt_rdy = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
